vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal porch and sync widths, in clocks; H_TOTAL is the sum of all four.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical widths, in lines; V_TOTAL is the sum of all four.
REQ-004 Parameters HSYNC_POL/VSYNC_POL, default 0: asserted sync level (0 = active low).
REQ-005 Parameter CH_W, default 1: bits per colour channel; PIX_W = 3*CH_W, ordered {R,G,B}.
REQ-006 Parameter FB_LATENCY, default 1, range 0..4: clocks from fb_x/fb_y to a valid fb_pixel.
REQ-007 clk  in  1  pixel clock; the only clock in the block.
REQ-008 rst  in  1  reset; synchronous, active-high.
REQ-009 mode  in  2  pattern select: 0 framebuffer, 1 colour bars, 2 checkerboard, 3 border.
REQ-010 fb_x  out  XW  current column; XW = clog2(H_TOTAL).
REQ-011 fb_y  out  YW  current line; YW = clog2(V_TOTAL).
REQ-012 fb_req  out  1  high when (fb_x,fb_y) is inside the active area.
REQ-013 fb_pixel  in  PIX_W  framebuffer data, valid FB_LATENCY clocks after its request.
REQ-014 pixel  out  PIX_W  colour output.
REQ-015 hsync_out, vsync_out  out  1 each  sync outputs.
REQ-016 de_out  out  1  display enable, aligned with pixel.
REQ-017 frame_start  out  1  one-clock pulse, aligned with output pixel (0,0).

Function
REQ-018 h_cnt shall count 0..H_TOTAL-1 and wrap to 0; v_cnt shall increment when h_cnt wraps, count 0..V_TOTAL-1 and wrap to 0.
REQ-019 fb_x, fb_y and fb_req shall be combinational from h_cnt/v_cnt; active means h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-020 hsync shall be asserted while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-021 vsync shall be asserted while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
REQ-022 Sync, active and frame-start flags shall be delayed FB_LATENCY clocks, then registered with pixel; total latency from counter value to outputs = FB_LATENCY+1 clocks.
REQ-023 While delayed active=0, pixel shall be all zeros, whatever the mode.
REQ-024 Mode 0: pixel = fb_pixel.
REQ-025 Mode 1: bar b = x*8/H_ACTIVE (0..7); R = all ones if b[2], G = all ones if b[1], B = all ones if b[0], otherwise zeros.
REQ-026 Mode 2: white (all ones) if x[3]^y[3], otherwise black.
REQ-027 Mode 3: white on x=0, x=H_ACTIVE-1, y=0 and y=V_ACTIVE-1; elsewhere fb_pixel.
REQ-028 The x/y that select the pattern shall be delayed with the flags, so pattern pixels line up with framebuffer pixels.
REQ-029 mode shall be sampled into mode_q only on the last counter cycle of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1); mode_q takes effect from the next (0,0).
REQ-030 mode_q shall stay constant in the output stage for a whole frame, including the pipeline tail of the previous frame.
REQ-031 frame_start shall be high for exactly one clock per frame, and never on the first output cycle after reset.

Reset
REQ-032 While rst is high: h_cnt=0, v_cnt=0, mode_q=0, all delay stages cleared; pixel=0, de_out=0, frame_start=0, hsync_out=~HSYNC_POL, vsync_out=~VSYNC_POL.
REQ-033 The first clock after rst falls shall present counter (0,0); reset mid-frame shall abandon the frame with no partial sync pulse extended.
REQ-034 Pipeline outputs shall hold their reset values until FB_LATENCY+1 clocks after release.

Structure
REQ-035 Package vga_pkg shall hold: the mode enum, the default 640x480@60 timing constants, and a clog2 function.
REQ-036 Sub-module vga_timing shall contain the counters and the sync/active decode; vga_scanout shall contain the delay line, mode latch and pattern mux.

Verification
REQ-037 Defaults, reset then 2 frames -> frame_start period 420000 clocks; hsync_out low 96 clocks per line; vsync_out low 1600 clocks per frame.
REQ-038 FB_LATENCY=2, fb model returns fb_x[2:0] -> output pixel at active column n = n mod 8; first de_out 3 clocks after fb_x=0.
REQ-039 mode=1 applied at line 100 -> framebuffer data until next frame_start, then x 0..79 = 3'b000, 80..159 = 3'b001, ..., 560..639 = 3'b111.
REQ-040 rst pulsed at line 200 -> syncs inactive, pixel=0 next clock; counters restart; next frame_start exactly 1+420000 clocks after release.
REQ-041 H=8/2/2/2, V=4/1/1/1, POL=1, FB_LATENCY=0 -> line length 14, hsync high at h_cnt 10..11, correct wrap, frame period 98 clocks.
REQ-042 mode=2, CH_W=2 -> pixel (8,0)=6'h3F, (0,0)=6'h00, (8,8)=6'h00; blanking pixels zero.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: pattern modes, default 640x480@60 timing and a width helper shared by the scanout blocks.
package vga_pkg;
    typedef enum logic [1:0] {MODE_FB, MODE_BARS, MODE_CHECK, MODE_BORDER} mode_e;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP = 33;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster counters with sync/active decode and frame boundary flags.
module vga_timing import vga_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP,
    parameter int XW = 10,
    parameter int YW = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic [XW-1:0] h_cnt,
    output logic [YW-1:0] v_cnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_last,
    output logic          frame_first
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    logic h_last, v_last, armed;
    assign h_last = int'(h_cnt) == H_TOTAL - 1;
    assign v_last = int'(v_cnt) == V_TOTAL - 1;
    assign active = int'(h_cnt) < H_ACTIVE && int'(v_cnt) < V_ACTIVE;
    assign hsync = int'(h_cnt) >= H_ACTIVE + H_FP && int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC;
    assign vsync = int'(v_cnt) >= V_ACTIVE + V_FP && int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC;
    assign frame_last = h_last && v_last;
    // Only an origin reached by wrapping is a frame start; the origin right after reset is not.
    assign frame_first = armed && h_cnt == '0 && v_cnt == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            armed <= 1'b0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            if (frame_last) armed <= 1'b1;
        end
    end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: raster scanout with framebuffer fetch alignment, per-frame mode latch and test patterns.
module vga_scanout import vga_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CH_W = 1,
    parameter int FB_LATENCY = 1,
    localparam int PIX_W = 3 * CH_W,
    localparam int XW = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int YW = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    output logic [XW-1:0]    fb_x,
    output logic [YW-1:0]    fb_y,
    output logic             fb_req,
    input  logic [PIX_W-1:0] fb_pixel,
    output logic [PIX_W-1:0] pixel,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             de_out,
    output logic             frame_start
);
    typedef struct packed {
        mode_e         mode;
        logic          hs;
        logic          vs;
        logic          act;
        logic          fs;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } tap_t;
    localparam int D = FB_LATENCY > 0 ? FB_LATENCY : 1;
    mode_e mode_q;
    logic hs, vs, last, first, border, chk;
    logic [2:0] bar;
    logic [PIX_W-1:0] pat;
    tap_t cur, tap;
    tap_t pipe [D];

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .XW(XW), .YW(YW)
    ) u_timing (
        .clk(clk), .rst(rst), .h_cnt(fb_x), .v_cnt(fb_y), .active(fb_req),
        .hsync(hs), .vsync(vs), .frame_last(last), .frame_first(first)
    );

    // Mode travels with each pixel so the previous frame's tail drains in its own mode.
    assign cur = '{mode: mode_q, hs: hs, vs: vs, act: fb_req, fs: first, x: fb_x, y: fb_y};
    assign tap = FB_LATENCY == 0 ? cur : pipe[D-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_FB;
            for (int i = 0; i < D; i++) pipe[i] <= '0;
        end else begin
            if (last) mode_q <= mode_e'(mode);
            pipe[0] <= cur;
            for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        bar = 3'(int'(tap.x) * 8 / H_ACTIVE);
        chk = 1'(tap.x >> 3) ^ 1'(tap.y >> 3);
        border = tap.x == '0 || int'(tap.x) == H_ACTIVE - 1 || tap.y == '0 || int'(tap.y) == V_ACTIVE - 1;
        pat = tap.mode == MODE_BARS ? {{CH_W{bar[2]}}, {CH_W{bar[1]}}, {CH_W{bar[0]}}} :
              tap.mode == MODE_CHECK ? {PIX_W{chk}} :
              tap.mode == MODE_BORDER && border ? {PIX_W{1'b1}} : fb_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel <= '0;
            de_out <= 1'b0;
            frame_start <= 1'b0;
            hsync_out <= !HSYNC_POL;
            vsync_out <= !VSYNC_POL;
        end else begin
            pixel <= tap.act ? pat : '0;
            de_out <= tap.act;
            frame_start <= tap.fs;
            hsync_out <= tap.hs ^ !HSYNC_POL;
            vsync_out <= tap.vs ^ !VSYNC_POL;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: randomized mode/reset stimulus on two vga_scanout configurations, scoreboarded against an arithmetic raster model.
module tb_vga_scanout;
    localparam int HA [2] = '{8, 32};
    localparam int HF [2] = '{2, 4};
    localparam int HS [2] = '{2, 6};
    localparam int HB [2] = '{2, 6};
    localparam int VA [2] = '{4, 20};
    localparam int VF [2] = '{1, 2};
    localparam int VS [2] = '{1, 2};
    localparam int VB [2] = '{1, 3};
    localparam int POL [2] = '{1, 0};
    localparam int LAT [2] = '{0, 2};
    localparam int CHW [2] = '{1, 2};
    localparam int CYCLES = 12000;

    typedef struct {
        int id; int tgt; int cx; int cy; int req; int de; int hs; int vs; int fs; int pix;
    } rec_t;

    logic clk = 1'b0;
    logic drv_rst [2];
    logic [1:0] drv_mode [2];
    logic [3:0] fb_x_a;
    logic [2:0] fb_y_a;
    logic fb_req_a, hs_a, vs_a, de_a, fs_a;
    logic [2:0] fb_pixel_a, pixel_a;
    logic [5:0] fb_x_b, bx1, bx2;
    logic [4:0] fb_y_b, by1, by2;
    logic fb_req_b, hs_b, vs_b, de_b, fs_b;
    logic [5:0] fb_pixel_b, pixel_b;
    logic [5:0] mem [2][2048];
    rec_t q[$];
    int modes [2][1024];
    int r [2];
    int hold [2];
    int fs_seen [2];
    int de_seen [2];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CH_W(1), .FB_LATENCY(0)
    ) u_dut_a (
        .clk(clk), .rst(drv_rst[0]), .mode(drv_mode[0]), .fb_x(fb_x_a), .fb_y(fb_y_a), .fb_req(fb_req_a),
        .fb_pixel(fb_pixel_a), .pixel(pixel_a), .hsync_out(hs_a), .vsync_out(vs_a), .de_out(de_a),
        .frame_start(fs_a)
    );

    vga_scanout #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CH_W(2), .FB_LATENCY(2)
    ) u_dut_b (
        .clk(clk), .rst(drv_rst[1]), .mode(drv_mode[1]), .fb_x(fb_x_b), .fb_y(fb_y_b), .fb_req(fb_req_b),
        .fb_pixel(fb_pixel_b), .pixel(pixel_b), .hsync_out(hs_b), .vsync_out(vs_b), .de_out(de_b),
        .frame_start(fs_b)
    );

    // Framebuffer models: random contents, answering after each instance's fetch latency.
    assign fb_pixel_a = mem[0][int'(fb_y_a) * 14 + int'(fb_x_a)][2:0];
    assign fb_pixel_b = mem[1][int'(by2) * 48 + int'(bx2)];
    always @(posedge clk) begin
        bx1 <= fb_x_b;
        bx2 <= bx1;
        by1 <= fb_y_b;
        by2 <= by1;
    end

    function automatic int h_tot(int id);
        return HA[id] + HF[id] + HS[id] + HB[id];
    endfunction

    function automatic int f_tot(int id);
        return h_tot(id) * (VA[id] + VF[id] + VS[id] + VB[id]);
    endfunction

    // Output expected while the raster position t (clocks since release) is on screen; t<0 means idle.
    function automatic rec_t model(int id, int t);
        rec_t e;
        int ht, f, p, x, y, b, ch, all;
        e = '{default: 0};
        e.id = id;
        e.hs = 1 - POL[id];
        e.vs = 1 - POL[id];
        if (t < 0) return e;
        ht = h_tot(id);
        f = t / f_tot(id);
        p = t % f_tot(id);
        x = p % ht;
        y = p / ht;
        ch = (1 << CHW[id]) - 1;
        all = (1 << (3 * CHW[id])) - 1;
        e.de = (x < HA[id] && y < VA[id]) ? 1 : 0;
        if (x >= HA[id] + HF[id] && x < HA[id] + HF[id] + HS[id]) e.hs = POL[id];
        if (y >= VA[id] + VF[id] && y < VA[id] + VF[id] + VS[id]) e.vs = POL[id];
        e.fs = (p == 0 && f > 0) ? 1 : 0;
        if (e.de != 0) begin
            b = x * 8 / HA[id];
            case (modes[id][f])
                1: e.pix = ((b / 4) % 2) * (ch << (2 * CHW[id])) + ((b / 2) % 2) * (ch << CHW[id]) + (b % 2) * ch;
                2: e.pix = ((x / 8 + y / 8) % 2 == 1) ? all : 0;
                3: e.pix = (x == 0 || y == 0 || x == HA[id] - 1 || y == VA[id] - 1) ? all : int'(mem[id][y * ht + x]) & all;
                default: e.pix = int'(mem[id][y * ht + x]) & all;
            endcase
        end
        return e;
    endfunction

    task automatic check(string name, int id, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, id, cyc, act, exp);
        end
    endtask

    task automatic compare(rec_t e, int x, int y, int req, int pix, int de, int hs, int vs, int fs);
        check("fb_x", e.id, x, e.cx);
        check("fb_y", e.id, y, e.cy);
        check("fb_req", e.id, req, e.req);
        check("pixel", e.id, pix, e.pix);
        check("de_out", e.id, de, e.de);
        check("hsync_out", e.id, hs, e.hs);
        check("vsync_out", e.id, vs, e.vs);
        check("frame_start", e.id, fs, e.fs);
        fs_seen[e.id] += fs;
        de_seen[e.id] += de;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tgt <= cyc) begin
            automatic rec_t e = q.pop_front();
            if (e.tgt != cyc) check("schedule", e.id, e.tgt, cyc);
            else if (e.id == 0)
                compare(e, int'(fb_x_a), int'(fb_y_a), int'(fb_req_a), int'(pixel_a), int'(de_a), int'(hs_a), int'(vs_a), int'(fs_a));
            else
                compare(e, int'(fb_x_b), int'(fb_y_b), int'(fb_req_b), int'(pixel_b), int'(de_b), int'(hs_b), int'(vs_b), int'(fs_b));
        end
    end

    initial begin
        for (int id = 0; id < 2; id++) begin
            drv_rst[id] = 1'b1;
            drv_mode[id] = 2'd0;
            hold[id] = 2;
            r[id] = 0;
            fs_seen[id] = 0;
            de_seen[id] = 0;
            for (int k = 0; k < 1024; k++) modes[id][k] = 0;
            for (int a = 0; a < 2048; a++) mem[id][a] = 6'($urandom);
        end
        repeat (CYCLES) begin
            @(posedge clk);
            #1;
            for (int id = 0; id < 2; id++) begin
                automatic rec_t e;
                automatic int nr, k, p;
                automatic bit in_rst;
                if (hold[id] == 0 && $urandom_range(0, id == 0 ? 3000 : 6000) == 0) hold[id] = $urandom_range(1, 3);
                if ($urandom_range(0, 299) == 0) drv_mode[id] = 2'($urandom_range(0, 3));
                in_rst = hold[id] > 0;
                if (in_rst) hold[id]--;
                drv_rst[id] = in_rst;
                k = (r[id] + 1) / f_tot(id);
                if (!in_rst && (r[id] + 1) % f_tot(id) == 0 && k < 1024) modes[id][k] = int'(drv_mode[id]);
                if (in_rst) modes[id][0] = 0;
                nr = in_rst ? 0 : r[id] + 1;
                e = model(id, in_rst ? -1 : nr - LAT[id] - 1);
                p = nr % f_tot(id);
                e.cx = p % h_tot(id);
                e.cy = p / h_tot(id);
                e.req = (e.cx < HA[id] && e.cy < VA[id]) ? 1 : 0;
                e.tgt = cyc + 1;
                q.push_back(e);
                r[id] = nr;
            end
        end
        repeat (4) @(posedge clk);
        check("queue_drained", 0, q.size(), 0);
        for (int id = 0; id < 2; id++) begin
            check("frame_start_seen", id, int'(fs_seen[id] > 0), 1);
            check("de_seen", id, int'(de_seen[id] > 0), 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
